// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: SPI serial-clock burst engine with programmable divide, CPOL/CPHA modes,
// lead/trail half-periods and sample/shift strobes aligned to the visible SCLK edges.
module spi_sclk_gen #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [DIV_W-1:0] i_div,
  input  logic [CNT_W-1:0] i_nbits,
  input  logic             i_cpol,
  input  logic             i_cpha,
  output logic             o_sclk,
  output logic             o_busy,
  output logic             o_sample,
  output logic             o_shift,
  output logic             o_done
);
  typedef enum logic [1:0] {IDLE, LEAD, RUN, TRAIL} state_t;
  state_t           state_q, state_d;
  logic [DIV_W-1:0] hcnt_q, hcnt_d, div_q, div_d;
  logic [CNT_W:0]   ecnt_q, ecnt_d, edge_k;
  logic [CNT_W-1:0] nbits_q, nbits_d;
  logic             cpol_q, cpol_d, cpha_q, cpha_d;
  logic             sclk_q, sclk_d, sample_q, sample_d, shift_q, shift_d, done_q, done_d;
  logic             half_done, last_edge, lead_edge;
  // edge_k is the number of the edge that would be emitted when the current half-period ends
  assign edge_k    = ecnt_q + 1'b1;
  assign half_done = hcnt_q == div_q;
  assign last_edge = edge_k == {nbits_q, 1'b0};
  assign lead_edge = edge_k[0];
  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    ecnt_d   = ecnt_q;
    div_d    = div_q;
    nbits_d  = nbits_q;
    cpol_d   = cpol_q;
    cpha_d   = cpha_q;
    sclk_d   = sclk_q;
    sample_d = 1'b0;
    shift_d  = 1'b0;
    done_d   = 1'b0;
    if (state_q == IDLE) begin
      sclk_d = i_cpol;
      if (i_start && i_nbits != '0) begin
        state_d = LEAD;
        hcnt_d  = '0;
        ecnt_d  = '0;
        div_d   = i_div;
        nbits_d = i_nbits;
        cpol_d  = i_cpol;
        cpha_d  = i_cpha;
      end
    end else if (i_abort) begin
      state_d = IDLE;
      sclk_d  = cpol_q;
    end else begin
      hcnt_d = half_done ? '0 : hcnt_q + 1'b1;
      if (half_done && state_q == TRAIL) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else if (half_done) begin
        sclk_d   = ~sclk_q;
        ecnt_d   = edge_k;
        state_d  = last_edge ? TRAIL : RUN;
        sample_d = lead_edge ^ cpha_q;
        shift_d  = cpha_q ? lead_edge : (!lead_edge && !last_edge);
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= IDLE;
      hcnt_q   <= '0;
      ecnt_q   <= '0;
      div_q    <= '0;
      nbits_q  <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      sclk_q   <= 1'b0;
      sample_q <= 1'b0;
      shift_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      ecnt_q   <= ecnt_d;
      div_q    <= div_d;
      nbits_q  <= nbits_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      sclk_q   <= sclk_d;
      sample_q <= sample_d;
      shift_q  <= shift_d;
      done_q   <= done_d;
    end
  end
  assign o_sclk   = sclk_q;
  assign o_busy   = state_q != IDLE;
  assign o_sample = sample_q;
  assign o_shift  = shift_q;
  assign o_done   = done_q;
endmodule

// File: tb/tb_spi_sclk_gen.sv
// tb_spi_sclk_gen: per-cycle scoreboard of {sclk,busy,sample,shift,done} derived from the
// burst timing formulas; an empty queue means the engine must sit idle.
module tb_spi_sclk_gen;
  logic       clk = 1'b0;
  logic       i_reset, i_start, i_abort, i_cpol, i_cpha;
  logic [7:0] i_div;
  logic [5:0] i_nbits;
  logic       o_sclk, o_busy, o_sample, o_shift, o_done;
  logic [4:0] exp_q[$];
  int         n_tests = 0;
  int         n_fail = 0;
  always #5 clk = ~clk;
  spi_sclk_gen dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_abort(i_abort),
    .i_div(i_div), .i_nbits(i_nbits), .i_cpol(i_cpol), .i_cpha(i_cpha),
    .o_sclk(o_sclk), .o_busy(o_busy), .o_sample(o_sample), .o_shift(o_shift), .o_done(o_done)
  );
  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: {sclk,busy,sample,shift,done} got %b want %b", tag, $time, got, exp);
    end
  endtask
  task automatic cyc(input string tag);
    logic       p;
    logic [4:0] e;
    p = i_cpol;
    @(posedge clk);
    #1;
    e = exp_q.size() != 0 ? exp_q.pop_front() : {p, 4'b0000};
    check(tag, {o_sclk, o_busy, o_sample, o_shift, o_done}, e);
  endtask
  // Expected vectors for cycles T0+1 .. T0+1+(2N+1)H, straight from the edge-timing formulas
  task automatic push_burst(input int div, input int n, input logic cpol, input logic cpha);
    int   h, tot, e;
    logic ed, ld;
    h   = div + 1;
    tot = (2 * n + 1) * h;
    for (int c = 1; c <= tot; c++) begin
      e  = (c - 1) / h;
      ed = ((c - 1) % h == 0) && e >= 1;
      ld = (e % 2) == 1;
      exp_q.push_back({cpol ^ ld, 1'b1, ed && (cpha ? !ld : ld),
                       ed && (cpha ? ld : (!ld && e != 2 * n)), 1'b0});
    end
    exp_q.push_back({cpol, 4'b0001});
  endtask
  task automatic start_burst(input int div, input int n, input logic cpol, input logic cpha,
                             input string tag);
    i_div   = 8'(div);
    i_nbits = 6'(n);
    i_cpol  = cpol;
    i_cpha  = cpha;
    i_start = 1'b1;
    push_burst(div, n, cpol, cpha);
    cyc(tag);
    i_start = 1'b0;
    i_div   = 8'($urandom);
    i_nbits = 6'($urandom);
    i_cpha  = 1'($urandom);
  endtask
  task automatic run_burst(input int div, input int n, input logic cpol, input logic cpha,
                           input string tag);
    start_burst(div, n, cpol, cpha, tag);
    repeat ((2 * n + 1) * (div + 1)) cyc(tag);
  endtask
  initial begin
    i_reset = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_cpol = 1'b0; i_cpha = 1'b0;
    i_div = '0; i_nbits = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", {o_sclk, o_busy, o_sample, o_shift, o_done}, 5'b0);
    i_reset = 1'b1;
    repeat (2) cyc("idle");
    run_burst(0, 8, 1'b0, 1'b0, "div0_n8_m0");
    repeat (2) cyc("gap");
    i_cpol = 1'b1;
    repeat (3) cyc("idle_cpol1");
    run_burst(3, 2, 1'b1, 1'b1, "div3_n2_m3");
    i_cpol = 1'b0;
    repeat (2) cyc("gap");
    run_burst(255, 1, 1'b0, 1'b1, "div255_n1");
    run_burst(1, 3, 1'b1, 1'b0, "b2b_a");
    run_burst(2, 2, 1'b0, 1'b1, "b2b_b");
    i_cpol  = 1'b0;
    i_nbits = '0;
    i_start = 1'b1;
    cyc("nbits0");
    i_start = 1'b0;
    repeat (5) cyc("nbits0_quiet");
    start_burst(0, 8, 1'b0, 1'b0, "abort_run");
    i_cpol = 1'b0;
    repeat (2) cyc("abort_run");
    i_start = 1'b1;
    i_nbits = 6'd5;
    cyc("abort_midstart");
    i_start = 1'b0;
    repeat (3) cyc("abort_run");
    i_abort = 1'b1;
    exp_q.delete();
    cyc("abort_next");
    i_abort = 1'b0;
    repeat (25) cyc("abort_quiet");
    start_burst(2, 4, 1'b1, 1'b0, "rst_run");
    i_cpol = 1'b1;
    repeat (10) cyc("rst_run");
    #3;
    i_reset = 1'b0;
    #1;
    check("async_rst", {o_sclk, o_busy, o_sample, o_shift, o_done}, 5'b0);
    exp_q.delete();
    i_cpol = 1'b0;
    @(posedge clk);
    #1;
    check("rst_held", {o_sclk, o_busy, o_sample, o_shift, o_done}, 5'b0);
    i_reset = 1'b1;
    repeat (2) cyc("post_rst_idle");
    run_burst(1, 5, 1'b1, 1'b1, "post_rst");
    i_cpol = 1'b0;
    repeat (3) cyc("tail");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
